// File: rtl/draw_text_box.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : draw_text_box                                                   |
// | Purpose  : Text-window overlay for the VGA pixel pipeline. Draws a grid of |
// |            2**ROW_BITS x 2**COL_BITS cells of 8x16 glyphs, scaled by        |
// |            2**SCALE_LOG2, at a runtime position that is only updated on a  |
// |            vsync rising edge. Supports a transparent background and a      |
// |            blinking (inverted) cursor cell.                                 |
// | Ports    : pclk/rst            pixel clock, async active-high reset        |
// |            *_in timing, rgb_in upstream raster and pixel colour            |
// |            box_x/box_y         requested top-left corner (frame-latched)   |
// |            transparent         background pixels pass rgb_in through      |
// |            cursor_en/_col/_row blinking cursor cell                        |
// |            char_xy/char_line   cell address and glyph line to font path    |
// |            char_pixels         glyph row returned FONT_LAT clocks later    |
// |            *_out, rgb_out      raster delayed FONT_LAT+2 clocks + pixel    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module draw_text_box #(
  parameter int          COL_BITS     = 4,
  parameter int          ROW_BITS     = 3,
  parameter int          SCALE_LOG2   = 0,
  parameter int          FONT_LAT     = 1,
  parameter logic [10:0] X_INIT       = 11'd454,
  parameter logic [10:0] Y_INIT       = 11'd96,
  parameter int          BLINK_FRAMES = 30,
  parameter logic [11:0] BG_COLOR     = 12'h000,
  parameter logic [11:0] FG_COLOR     = 12'h06f
) (
  input  logic                         pclk,
  input  logic                         rst,
  input  logic [10:0]                  hcount_in,
  input  logic                         hsync_in,
  input  logic                         hblnk_in,
  input  logic [10:0]                  vcount_in,
  input  logic                         vsync_in,
  input  logic                         vblnk_in,
  input  logic [11:0]                  rgb_in,
  input  logic [10:0]                  box_x,
  input  logic [10:0]                  box_y,
  input  logic                         transparent,
  input  logic                         cursor_en,
  input  logic [COL_BITS-1:0]          cursor_col,
  input  logic [ROW_BITS-1:0]          cursor_row,
  input  logic [7:0]                   char_pixels,
  output logic [10:0]                  hcount_out,
  output logic                         hsync_out,
  output logic                         hblnk_out,
  output logic [10:0]                  vcount_out,
  output logic                         vsync_out,
  output logic                         vblnk_out,
  output logic [11:0]                  rgb_out,
  output logic [ROW_BITS+COL_BITS-1:0] char_xy,
  output logic [3:0]                   char_line
);

  // Box extent in pixels; 12 bits so the right/bottom edge never wraps.
  localparam logic [11:0] C_BOX_W = 12'((8 << SCALE_LOG2) << COL_BITS);
  localparam logic [11:0] C_BOX_H = 12'((16 << SCALE_LOG2) << ROW_BITS);
  localparam int          C_BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [C_BLINK_W-1:0] C_BLINK_LAST = C_BLINK_W'(BLINK_FRAMES - 1);

  // Everything that travels alongside a pixel while the font lookup is in flight.
  typedef struct packed {
    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic [11:0] rgb;
    logic        in_box;
    logic [2:0]  px;
    logic        inv;
    logic        transp;
  } pix_t;

  // --------------------------------------------------------------------------
  // Frame-synchronous position and cursor blink state
  // --------------------------------------------------------------------------
  logic [10:0]          bx_q, bx_d;
  logic [10:0]          by_q, by_d;
  logic                 vsync_prev_q;
  logic [C_BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic                 blink_phase_q, blink_phase_d;
  logic                 w_frame_start;

  assign w_frame_start = vsync_in & ~vsync_prev_q;

  always_comb begin
    bx_d          = bx_q;
    by_d          = by_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (w_frame_start) begin
      bx_d = box_x;
      by_d = box_y;
      if (blink_cnt_q == C_BLINK_LAST) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + C_BLINK_W'(1);
      end
    end
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      bx_q          <= X_INIT;
      by_q          <= Y_INIT;
      vsync_prev_q  <= 1'b0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      bx_q          <= bx_d;
      by_q          <= by_d;
      vsync_prev_q  <= vsync_in;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 1: box-relative coordinates, cell address, cursor hit
  // --------------------------------------------------------------------------
  logic [11:0]                  w_h_ext, w_v_ext, w_bx_ext, w_by_ext;
  logic [10:0]                  w_rx, w_ry;
  logic                         w_in_box;
  logic [COL_BITS-1:0]          w_col;
  logic [ROW_BITS-1:0]          w_row;
  logic [3:0]                   w_line;
  logic [2:0]                   w_px;
  logic                         w_cursor_hit;
  pix_t                         s1_d, s1_q;
  logic [ROW_BITS+COL_BITS-1:0] char_xy_d, char_xy_q;
  logic [3:0]                   char_line_d, char_line_q;

  assign w_h_ext  = {1'b0, hcount_in};
  assign w_v_ext  = {1'b0, vcount_in};
  assign w_bx_ext = {1'b0, bx_q};
  assign w_by_ext = {1'b0, by_q};

  // rx/ry wrap when left of / above the box; in_box masks those cases.
  assign w_rx = hcount_in - bx_q;
  assign w_ry = vcount_in - by_q;

  assign w_in_box = (w_h_ext >= w_bx_ext) && (w_h_ext < w_bx_ext + C_BOX_W) &&
                    (w_v_ext >= w_by_ext) && (w_v_ext < w_by_ext + C_BOX_H);

  assign w_col  = COL_BITS'(w_rx >> (SCALE_LOG2 + 3));
  assign w_row  = ROW_BITS'(w_ry >> (SCALE_LOG2 + 4));
  assign w_line = 4'(w_ry >> SCALE_LOG2);
  assign w_px   = 3'(w_rx >> SCALE_LOG2);

  assign w_cursor_hit = w_in_box && (w_col == cursor_col) && (w_row == cursor_row);

  always_comb begin
    s1_d        = '0;
    s1_d.hcount = hcount_in;
    s1_d.hsync  = hsync_in;
    s1_d.hblnk  = hblnk_in;
    s1_d.vcount = vcount_in;
    s1_d.vsync  = vsync_in;
    s1_d.vblnk  = vblnk_in;
    s1_d.rgb    = rgb_in;
    s1_d.in_box = w_in_box;
    s1_d.px     = w_px;
    // Cursor inversion is resolved here so only one bit rides the pipeline.
    s1_d.inv    = w_cursor_hit & cursor_en & blink_phase_q;
    s1_d.transp = transparent;

    char_xy_d   = w_in_box ? {w_row, w_col} : '0;
    char_line_d = w_in_box ? w_line : 4'd0;
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      s1_q        <= '0;
      char_xy_q   <= '0;
      char_line_q <= '0;
    end else begin
      s1_q        <= s1_d;
      char_xy_q   <= char_xy_d;
      char_line_q <= char_line_d;
    end
  end

  assign char_xy   = char_xy_q;
  assign char_line = char_line_q;

  // --------------------------------------------------------------------------
  // Delay line matching the external font path latency
  // --------------------------------------------------------------------------
  pix_t dly_q [FONT_LAT];

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FONT_LAT; i++) begin
        dly_q[i] <= '0;
      end
    end else begin
      dly_q[0] <= s1_q;
      for (int i = 1; i < FONT_LAT; i++) begin
        dly_q[i] <= dly_q[i-1];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Final stage: glyph bit select and colour compositing
  // --------------------------------------------------------------------------
  pix_t        w_last;
  logic        w_glyph_bit;
  logic        w_fg;
  logic [11:0] rgb_d;

  assign w_last = dly_q[FONT_LAT-1];

  always_comb begin
    w_glyph_bit = char_pixels[3'd7 - w_last.px];
    w_fg        = w_glyph_bit ^ w_last.inv;
    rgb_d       = '0;
    if (w_last.hblnk || w_last.vblnk) begin
      rgb_d = '0;
    end else if (!w_last.in_box) begin
      rgb_d = w_last.rgb;
    end else if (w_fg) begin
      rgb_d = FG_COLOR;
    end else if (w_last.transp) begin
      rgb_d = w_last.rgb;
    end else begin
      rgb_d = BG_COLOR;
    end
  end

  logic [10:0] hcount_q, vcount_q;
  logic        hsync_q, hblnk_q, vsync_q, vblnk_q;
  logic [11:0] rgb_q;

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      hcount_q <= '0;
      hsync_q  <= 1'b0;
      hblnk_q  <= 1'b0;
      vcount_q <= '0;
      vsync_q  <= 1'b0;
      vblnk_q  <= 1'b0;
      rgb_q    <= '0;
    end else begin
      hcount_q <= w_last.hcount;
      hsync_q  <= w_last.hsync;
      hblnk_q  <= w_last.hblnk;
      vcount_q <= w_last.vcount;
      vsync_q  <= w_last.vsync;
      vblnk_q  <= w_last.vblnk;
      rgb_q    <= rgb_d;
    end
  end

  assign hcount_out = hcount_q;
  assign hsync_out  = hsync_q;
  assign hblnk_out  = hblnk_q;
  assign vcount_out = vcount_q;
  assign vsync_out  = vsync_q;
  assign vblnk_out  = vblnk_q;
  assign rgb_out    = rgb_q;

endmodule
`default_nettype wire

// File: tb/tb_draw_text_box.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_draw_text_box                                                |
// | Purpose  : Directed bench for draw_text_box. Two instances share stimulus: |
// |            dut 0 uses defaults, dut 1 uses 2x scale, FONT_LAT=2 and a      |
// |            two-frame blink. A font ROM model answers char_xy/char_line.    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_draw_text_box;

  localparam int CB  = 4;
  localparam int RB  = 3;
  localparam int SC0 = 0;
  localparam int FL0 = 1;
  localparam int BF0 = 30;
  localparam int SC1 = 1;
  localparam int FL1 = 2;
  localparam int BF1 = 2;
  localparam logic [11:0] FGC = 12'h06f;
  localparam logic [11:0] BGC = 12'h000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] hcount_in = '0, vcount_in = '0;
  logic        hsync_in = 1'b0, hblnk_in = 1'b0, vsync_in = 1'b0, vblnk_in = 1'b0;
  logic [11:0] rgb_in = '0;
  logic [10:0] box_x = 11'd454, box_y = 11'd96;
  logic        transparent = 1'b0, cursor_en = 1'b0;
  logic [3:0]  cursor_col = '0;
  logic [2:0]  cursor_row = '0;
  int          font_mode = 0;

  logic [10:0] ho [2];
  logic [10:0] vo [2];
  logic        hso [2];
  logic        hbo [2];
  logic        vso [2];
  logic        vbo [2];
  logic [11:0] rgbo [2];
  logic [6:0]  xyo [2];
  logic [3:0]  lno [2];
  logic [7:0]  cp [2];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  draw_text_box #(.SCALE_LOG2(SC0), .FONT_LAT(FL0), .BLINK_FRAMES(BF0)) dut0 (
    .pclk(clk), .rst(rst),
    .hcount_in(hcount_in), .hsync_in(hsync_in), .hblnk_in(hblnk_in),
    .vcount_in(vcount_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .box_x(box_x), .box_y(box_y), .transparent(transparent),
    .cursor_en(cursor_en), .cursor_col(cursor_col), .cursor_row(cursor_row),
    .char_pixels(cp[0]),
    .hcount_out(ho[0]), .hsync_out(hso[0]), .hblnk_out(hbo[0]),
    .vcount_out(vo[0]), .vsync_out(vso[0]), .vblnk_out(vbo[0]),
    .rgb_out(rgbo[0]), .char_xy(xyo[0]), .char_line(lno[0])
  );

  draw_text_box #(.SCALE_LOG2(SC1), .FONT_LAT(FL1), .BLINK_FRAMES(BF1)) dut1 (
    .pclk(clk), .rst(rst),
    .hcount_in(hcount_in), .hsync_in(hsync_in), .hblnk_in(hblnk_in),
    .vcount_in(vcount_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .box_x(box_x), .box_y(box_y), .transparent(transparent),
    .cursor_en(cursor_en), .cursor_col(cursor_col), .cursor_row(cursor_row),
    .char_pixels(cp[1]),
    .hcount_out(ho[1]), .hsync_out(hso[1]), .hblnk_out(hbo[1]),
    .vcount_out(vo[1]), .vsync_out(vso[1]), .vblnk_out(vbo[1]),
    .rgb_out(rgbo[1]), .char_xy(xyo[1]), .char_line(lno[1])
  );

  // Font ROM model: glyph depends on cell address and line so a wrong
  // char_xy/char_line shows up as a wrong pixel.
  function automatic logic [7:0] font(input int mode, input logic [6:0] xy, input logic [3:0] ln);
    case (mode)
      0:       return 8'h80;
      1:       return 8'(int'(xy) * 37 + int'(ln) * 11) ^ 8'h5a;
      default: return 8'h00;
    endcase
  endfunction

  logic [7:0] rom0_q [FL0] = '{default: 8'h00};
  logic [7:0] rom1_q [FL1] = '{default: 8'h00};

  always @(posedge clk) begin
    rom0_q[0] <= font(font_mode, xyo[0], lno[0]);
    for (int i = 1; i < FL0; i++) rom0_q[i] <= rom0_q[i-1];
    rom1_q[0] <= font(font_mode, xyo[1], lno[1]);
    for (int i = 1; i < FL1; i++) rom1_q[i] <= rom1_q[i-1];
  end

  assign cp[0] = rom0_q[FL0-1];
  assign cp[1] = rom1_q[FL1-1];

  // Scoreboard
  typedef struct packed {
    logic [10:0] h;
    logic        hs;
    logic        hb;
    logic [10:0] v;
    logic        vs;
    logic        vb;
    logic [11:0] rgb;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int mbx [2];
  int mby [2];
  int mcnt [2];
  bit mph [2];
  bit mvs_prev;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic void model(input int k, output exp_t e, output logic [6:0] exy,
                                output logic [3:0] eln);
    int sc, w, ht, h, v, rx, ry, col, row, ln, px;
    bit inb, hit, fg;
    logic [7:0] g;
    sc  = (k == 0) ? SC0 : SC1;
    w   = (8 << sc) << CB;
    ht  = (16 << sc) << RB;
    h   = int'(hcount_in);
    v   = int'(vcount_in);
    inb = (h >= mbx[k]) && (h < mbx[k] + w) && (v >= mby[k]) && (v < mby[k] + ht);
    exy = '0;
    eln = '0;
    fg  = 1'b0;
    if (inb) begin
      rx  = h - mbx[k];
      ry  = v - mby[k];
      col = rx >> (sc + 3);
      row = ry >> (sc + 4);
      ln  = (ry >> sc) % 16;
      px  = (rx >> sc) % 8;
      exy = 7'(row * 16 + col);
      eln = 4'(ln);
      g   = font(font_mode, exy, eln);
      hit = cursor_en && (row == int'(cursor_row)) && (col == int'(cursor_col)) && mph[k];
      fg  = g[7 - px] ^ hit;
    end
    e.h  = hcount_in;
    e.hs = hsync_in;
    e.hb = hblnk_in;
    e.v  = vcount_in;
    e.vs = vsync_in;
    e.vb = vblnk_in;
    if (hblnk_in || vblnk_in)  e.rgb = 12'h000;
    else if (!inb)             e.rgb = rgb_in;
    else if (fg)               e.rgb = FGC;
    else if (transparent)      e.rgb = rgb_in;
    else                       e.rgb = BGC;
  endfunction

  function automatic void frame_update();
    int bf;
    if (vsync_in && !mvs_prev) begin
      for (int k = 0; k < 2; k++) begin
        bf     = (k == 0) ? BF0 : BF1;
        mbx[k] = int'(box_x);
        mby[k] = int'(box_y);
        if (mcnt[k] == bf - 1) begin
          mcnt[k] = 0;
          mph[k]  = !mph[k];
        end else begin
          mcnt[k] = mcnt[k] + 1;
        end
      end
    end
    mvs_prev = vsync_in;
  endfunction

  task automatic sb_reset();
    exp_t z;
    z = '0;
    q0.delete();
    q1.delete();
    repeat (FL0 + 1) q0.push_back(z);
    repeat (FL1 + 1) q1.push_back(z);
    for (int k = 0; k < 2; k++) begin
      mbx[k]  = 454;
      mby[k]  = 96;
      mcnt[k] = 0;
      mph[k]  = 1'b0;
    end
    mvs_prev = 1'b0;
  endtask

  task automatic cmp_dut(input int k, input exp_t e, input logic [6:0] x, input logic [3:0] l);
    check($sformatf("dut%0d rgb h=%0d v=%0d", k, e.h, e.v), 64'(rgbo[k]), 64'(e.rgb));
    check($sformatf("dut%0d timing h=%0d v=%0d", k, e.h, e.v),
          64'({ho[k], hso[k], hbo[k], vo[k], vso[k], vbo[k]}),
          64'({e.h, e.hs, e.hb, e.v, e.vs, e.vb}));
    check($sformatf("dut%0d char_xy/line", k), 64'({xyo[k], lno[k]}), 64'({x, l}));
  endtask

  // One pixel clock: drive, predict, clock, compare what is due.
  task automatic step(input int h, input int v, input bit hs, input bit hb,
                      input bit vs, input bit vb, input int rgb);
    exp_t e0, e1, d0, d1;
    logic [6:0] x0, x1;
    logic [3:0] l0, l1;
    hcount_in = 11'(h);
    vcount_in = 11'(v);
    hsync_in  = hs;
    hblnk_in  = hb;
    vsync_in  = vs;
    vblnk_in  = vb;
    rgb_in    = 12'(rgb);
    model(0, e0, x0, l0);
    model(1, e1, x1, l1);
    q0.push_back(e0);
    q1.push_back(e1);
    frame_update();
    @(posedge clk);
    #1;
    d0 = q0.pop_front();
    d1 = q1.pop_front();
    cmp_dut(0, d0, x0, l0);
    cmp_dut(1, d1, x1, l1);
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 0);
  endtask

  task automatic vsync_pulse();
    step(0, 800, 1'b0, 1'b1, 1'b1, 1'b1, 0);
    step(0, 801, 1'b0, 1'b1, 1'b0, 1'b1, 0);
  endtask

  task automatic all_zero(input string tag);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s dut%0d outputs", tag, k),
            64'({ho[k], hso[k], hbo[k], vo[k], vso[k], vbo[k], rgbo[k], xyo[k], lno[k]}),
            64'(0));
    end
  endtask

  int vlist [10] = '{96, 97, 111, 112, 130, 223, 224, 351, 352, 300};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    all_zero("reset");
    rst = 1'b0;
    sb_reset();

    // Default placement with a single-pixel glyph column
    font_mode = 0;
    for (int h = 450; h <= 470; h++) step(h, 96, (h % 7) == 0, 1'b0, 1'b0, 1'b0, h * 5);
    for (int v = 97; v <= 99; v++)
      for (int h = 452; h <= 458; h++) step(h, v, 1'b0, 1'b0, 1'b0, 1'b0, h + v);
    idle(4);

    // Varied glyphs across rows, columns and the box edges of both scales
    font_mode = 1;
    for (int i = 0; i < 10; i++)
      for (int h = 448; h <= 720; h += 7) step(h, vlist[i], (h % 5) == 0, 1'b0, 1'b0, 1'b0, h * 3 + i);
    step(581, 223, 1'b0, 1'b0, 1'b0, 1'b0, 12'h123);
    step(582, 223, 1'b0, 1'b0, 1'b0, 1'b0, 12'h124);
    step(709, 351, 1'b0, 1'b0, 1'b0, 1'b0, 12'h125);
    step(710, 351, 1'b0, 1'b0, 1'b0, 1'b0, 12'h126);
    step(460, 100, 1'b0, 1'b1, 1'b0, 1'b0, 12'hfff);
    step(460, 100, 1'b0, 1'b0, 1'b0, 1'b1, 12'hfff);
    idle(4);

    // Transparent background
    transparent = 1'b1;
    font_mode   = 2;
    for (int h = 450; h <= 470; h++) step(h, 100, 1'b0, 1'b0, 1'b0, 1'b0, 12'h800 + h);
    step(462, 100, 1'b0, 1'b1, 1'b0, 1'b0, 12'h7ab);
    idle(4);
    font_mode = 0;
    for (int h = 452; h <= 462; h++) step(h, 100, 1'b0, 1'b0, 1'b0, 1'b0, 12'h300 + h);
    idle(4);
    transparent = 1'b0;

    // Position change takes effect only on the next frame
    box_x = 11'd100;
    for (int h = 98; h <= 104; h++) step(h, 96, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0a0 + h);
    for (int h = 452; h <= 458; h++) step(h, 96, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0b0 + h);
    vsync_pulse();
    for (int h = 98; h <= 104; h++) step(h, 96, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0c0 + h);
    for (int h = 452; h <= 458; h++) step(h, 96, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0d0 + h);
    idle(4);

    // Blinking cursor over several frames
    cursor_en  = 1'b1;
    cursor_col = 4'd2;
    cursor_row = 3'd1;
    for (int f = 0; f < 6; f++) begin
      for (int h = 112; h <= 150; h += 2) step(h, 120, 1'b0, 1'b0, 1'b0, 1'b0, 12'h400 + h);
      for (int h = 112; h <= 150; h += 2) step(h, 130, 1'b0, 1'b0, 1'b0, 1'b0, 12'h500 + h);
      idle(4);
      vsync_pulse();
    end

    // Box running past the right edge of the count range
    box_x     = 11'd2000;
    font_mode = 1;
    vsync_pulse();
    for (int h = 2040; h <= 2047; h++) step(h, 100, 1'b0, 1'b0, 1'b0, 1'b0, 12'h600 + h);
    for (int h = 0; h <= 5; h++) step(h, 100, 1'b0, 1'b0, 1'b0, 1'b0, 12'h700 + h);
    cursor_en = 1'b0;

    // Asynchronous reset in the middle of a line
    for (int h = 2042; h <= 2046; h++) step(h, 101, 1'b1, 1'b0, 1'b0, 1'b0, 12'h9a0 + h);
    #3;
    rst = 1'b1;
    #1;
    all_zero("async reset");
    @(posedge clk);
    #1;
    all_zero("reset held");
    rst = 1'b0;
    sb_reset();
    font_mode = 0;
    for (int h = 450; h <= 462; h++) step(h, 96, (h % 3) == 0, 1'b0, 1'b0, 1'b0, 12'hb00 + h);
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
